// File: rtl/apb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge: controller state encoding and AHB response codes.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } apb_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase; flags expiry on the TIMEOUT-th consecutive wait cycle.
// Latency: expired is combinational from the current count and count_en.
// Backpressure: none; counter saturates, TIMEOUT=0 never expires.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic Hclk,
  input  logic Hresetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the wait cycles already spent, so the current one is cnt+1
  assign expired = (TIMEOUT != 0) && count_en && (cnt == LAST);

endmodule

// File: rtl/apb_ctrl_param.sv
// Parametrised APB master controller with wait-state, slave-error and timeout handling.
// Latency: read 2 / write 3 Hreadyout-low cycles at zero wait, +1 per Pready-low cycle.
// Backpressure: Hreadyout low while busy; AHB inputs ignored until it returns high.
module apb_ctrl_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [NSLV-1:0]   tempselx,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic [NSLV-1:0]   Pselx
);
  import apb_bridge_pkg::*;

  apb_state_t    state;
  logic [NSLV-1:0] sel_q;
  logic          accept;
  logic          sel_zero;
  logic          tmr_clear;
  logic          tmr_count;
  logic          tmr_expired;

  // Hreadyout is high exactly in IDLE and ERR2, the two states that may accept
  assign accept    = valid && Hreadyout;
  assign sel_zero  = (tempselx == '0);
  assign tmr_clear = (accept && !sel_zero && !Hwrite) || (state == WWAIT);
  assign tmr_count = (state == ACCESS) && !Pready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .Hclk     (Hclk),
    .Hresetn  (Hresetn),
    .clear    (tmr_clear),
    .count_en (tmr_count),
    .expired  (tmr_expired)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
      Penable   <= 1'b0;
      Pselx     <= '0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hrdata    <= '0;
      sel_q     <= '0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          Hresp <= HRESP_OKAY;
          if (accept) begin
            Paddr     <= Haddr;
            Pwrite    <= Hwrite;
            sel_q     <= tempselx;
            Hreadyout <= 1'b0;
            if (sel_zero) begin
              state <= ERR1;
              Hresp <= HRESP_ERROR;
            end else if (Hwrite) begin
              state <= WWAIT;
            end else begin
              state <= SETUP;
              Pselx <= tempselx;
            end
          end else begin
            state     <= IDLE;
            Hreadyout <= 1'b1;
          end
        end
        WWAIT: begin
          Pwdata <= Hwdata;
          Pselx  <= sel_q;
          state  <= SETUP;
        end
        SETUP: begin
          Penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (Pready || tmr_expired) begin
            Penable <= 1'b0;
            Pselx   <= '0;
            if (Pready && !Pslverr) begin
              state     <= IDLE;
              Hreadyout <= 1'b1;
              if (!Pwrite) begin
                Hrdata <= Prdata;
              end
            end else begin
              state <= ERR1;
              Hresp <= HRESP_ERROR;
            end
          end
        end
        ERR1: begin
          state     <= ERR2;
          Hreadyout <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          Hreadyout <= 1'b1;
          Hresp     <= HRESP_OKAY;
          Penable   <= 1'b0;
          Pselx     <= '0;
        end
      endcase
    end
  end

endmodule
